// File: rtl/timer_bank.sv
// timer_bank: bank of independent countdown timers sharing one free-running
// time base.
//
// Each channel loads a seconds value on `start`, counts it down in whole
// seconds measured from its own start edge, can be paused or aborted, and
// emits a one-cycle `expired` pulse when the count reaches zero.
//
// Parameters:
//   CLK_HZ   clock cycles per second (even, >= 2)
//   CHANNELS number of independent timers
//   VALUE_W  width of the per-channel seconds value
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous reset, active low
//   start           per-channel load/retrigger request
//   abort           per-channel cancel (highest priority)
//   pause           per-channel level, freezes the count while high
//   value           seconds to load, channel i at [i*VALUE_W +: VALUE_W]
//   expired         per-channel one-cycle pulse at end of count
//   busy            per-channel, high while running or paused
//   remaining       seconds left, same packing as value
//   one_hz_enable   one-cycle strobe once per second
//   half_hz_enable  one-cycle strobe twice per second
//   blink           square wave toggling on every one_hz_enable
module timer_bank #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int CHANNELS = 2,
  parameter int VALUE_W  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS-1:0]          abort,
  input  logic [CHANNELS-1:0]          pause,
  input  logic [CHANNELS*VALUE_W-1:0]  value,
  output logic [CHANNELS-1:0]          expired,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS*VALUE_W-1:0]  remaining,
  output logic                         one_hz_enable,
  output logic                         half_hz_enable,
  output logic                         blink
);

  localparam int PC_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(CLK_HZ - 1);
  localparam logic [PC_W-1:0] PC_HALF = PC_W'(CLK_HZ / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Shared time base
  // ---------------------------------------------------------------------
  logic [PC_W-1:0] pc;

  // NOTE: registers are assigned with <= so every flop samples the values
  // present before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      blink <= 1'b0;
    end else begin
      pc <= (pc == PC_LAST) ? '0 : pc + PC_W'(1);
      if (one_hz_enable) blink <= ~blink;
    end
  end

  assign one_hz_enable  = (pc == PC_LAST);
  assign half_hz_enable = (pc == PC_HALF) || (pc == PC_LAST);

  // ---------------------------------------------------------------------
  // Per-channel countdown FSMs
  // ---------------------------------------------------------------------
  state_t             state_q [CHANNELS];
  state_t             state_d [CHANNELS];
  logic [VALUE_W-1:0] rem_q   [CHANNELS];
  logic [VALUE_W-1:0] rem_d   [CHANNELS];
  logic [PC_W-1:0]    sc_q    [CHANNELS];
  logic [PC_W-1:0]    sc_d    [CHANNELS];

  // NOTE: the per-channel arrays are a handful of control flops, not a RAM,
  // so every entry is reset; the async reset must cancel a count at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        rem_q[i]   <= '0;
        sc_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
        sc_q[i]    <= sc_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: hold-current defaults come first so no path through the
      // decision tree leaves a signal unassigned (which would infer a latch).
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      sc_d[i]    = sc_q[i];

      if (abort[i]) begin
        state_d[i] = IDLE;
        rem_d[i]   = '0;
        sc_d[i]    = '0;
      end else if (start[i]) begin
        sc_d[i] = '0;
        if (value[i*VALUE_W +: VALUE_W] != '0) begin
          state_d[i] = RUN;
          rem_d[i]   = value[i*VALUE_W +: VALUE_W];
        end else begin
          state_d[i] = DONE;
          rem_d[i]   = '0;
        end
      end else begin
        case (state_q[i])
          RUN, PAUSE: begin
            if (pause[i]) begin
              state_d[i] = PAUSE;
            end else begin
              // Leaving PAUSE counts on the same edge, so a channel loses
              // exactly one cycle for every edge that saw pause high.
              state_d[i] = RUN;
              if (sc_q[i] != PC_LAST) begin
                sc_d[i] = sc_q[i] + PC_W'(1);
              end else begin
                sc_d[i]  = '0;
                rem_d[i] = rem_q[i] - VALUE_W'(1);
                if (rem_q[i] == VALUE_W'(1)) state_d[i] = DONE;
              end
            end
          end
          DONE:    state_d[i] = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    expired   = '0;
    busy      = '0;
    remaining = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      expired[i] = (state_q[i] == DONE);
      busy[i]    = (state_q[i] == RUN) || (state_q[i] == PAUSE);
      remaining[i*VALUE_W +: VALUE_W] = rem_q[i];
    end
  end

endmodule
